scan_chain_loader: RTL and testbench
====================================

// Module: scan_chain_loader
// PURPOSE
//   Parametrised successor to the single-bit configuration chain: a WIDTH-bit-per-shift
//   configuration chain of SC_LENGTH bits, with its own load controller.
//   Accepts bitstream words over a valid/ready handshake and counts words to completion.
//   Flags completion, abort and a valid configuration to the FPGA core fabric.
//   Sits between the bitstream decrypt/unpack path and the core's configuration cells.
// PARAMETERS
//   SC_LENGTH  1024  total configuration bits held; must be a multiple of WIDTH
//   WIDTH      8     bits shifted in per accepted word
//   DEPTH      SC_LENGTH/WIDTH (localparam)  words per full load
//   CNT_W      $clog2(DEPTH+1) (localparam)   width of word counter
// PORTS
//   clk           in   1          clock; all state changes on posedge
//   clear         in   1          reset: synchronous, active-high
//   start         in   1          pulse: begin a load (honoured only in IDLE)
//   abort         in   1          pulse: terminate a load in progress
//   data_i        in   WIDTH      bitstream word
//   valid_i       in   1          data_i valid
//   ready_o       out  1          loader accepts a word this cycle
//   busy_o        out  1          high in LOAD
//   done_o        out  1          one-cycle pulse: full load finished
//   cfg_valid_o   out  1          chain_o holds a complete configuration
//   incomplete_o  out  1          sticky: last load was aborted
//   word_cnt_o    out  CNT_W      words accepted in current/last load
//   chain_o       out  SC_LENGTH  configuration bits to the fabric
//   data_o        out  WIDTH      readback word (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: clear=1 at a posedge -> chain=0, state IDLE, word_cnt=0, every output 0.
//     clear overrides start/abort/valid_i in the same cycle; a clear mid-load discards the load.
//   - FSM states: IDLE, LOAD, DONE.
//   - IDLE: ready_o=0. start=1 -> LOAD; word_cnt=0; cfg_valid_o=0; incomplete_o=0.
//     The chain is NOT cleared on start.
//   - LOAD: ready_o=1, busy_o=1. Handshake = valid_i & ready_o. On a handshake:
//     chain <= {data_i, chain[SC_LENGTH-1:WIDTH]}; word_cnt++.
//     The first word accepted ends at chain[WIDTH-1:0] after DEPTH words.
//     No handshake -> chain and word_cnt hold.
//   - Load completion: the handshake that takes word_cnt from DEPTH-1 to DEPTH -> DONE.
//   - Abort in LOAD: abort=1 -> IDLE; incomplete_o=1; cfg_valid_o=0; chain and word_cnt hold.
//     abort together with a handshake in the same cycle: abort wins, the word is dropped.
//   - start while in LOAD/DONE: ignored. abort outside LOAD: ignored.
//   - DONE: lasts exactly 1 cycle. done_o=1, ready_o=0, busy_o=0. Next cycle -> IDLE with
//     cfg_valid_o=1, held until the next start or clear.
//   - Latency: done_o is high in the cycle after the last handshake edge.
//   - Throughput: 1 word/cycle. Full load = DEPTH+1 cycles from the first handshake to IDLE.
//   - word_cnt saturates at DEPTH and never wraps. It is reset only by start or clear.
//   - All outputs are registered, except ready_o/busy_o (decoded from state) and data_o.
// CONFIGURATION
//   SC_READBACK_EN defined:
//     - data_o = chain[WIDTH-1:0]: the word that the next handshake shifts out.
//     - A second full load streams the previous configuration out in original order,
//       allowing a readback compare.
//   SC_READBACK_EN undefined:
//     - data_o is tied to 0; no readback logic is synthesised.
// TESTING (SC_LENGTH=32, WIDTH=8, DEPTH=4)
//   1 clear=1 for 2 cycles -> chain_o=0, word_cnt_o=0, all flags 0, ready_o=0.
//   2 start; words 0x11,0x22,0x33,0x44 back-to-back -> chain_o=0x44332211; done_o high
//     1 cycle after the 4th handshake; cfg_valid_o=1; word_cnt_o=4.
//   3 Same words with valid_i low 3 cycles between words -> chain_o=0x44332211; word_cnt_o
//     holds across the gaps; done_o single pulse.
//   4 Load 0xAA,0xBB, then abort with valid_i=1 and data 0xCC -> IDLE; incomplete_o=1;
//     cfg_valid_o=0; word_cnt_o=2; 0xCC not shifted.
//   5 After test 2, clear during a second load at word 2 -> chain_o=0, state IDLE;
//     start in the same cycle as clear is ignored.
//   6 SC_READBACK_EN: after test 2, reload 0x55x4 -> data_o before each handshake =
//     0x11,0x22,0x33,0x44; macro off -> data_o=0 throughout.

Source files
------------

// File: rtl/scan_chain_loader.sv
// WIDTH-bit-per-shift configuration chain with a start/abort load controller and word counter.
// Optional readback of the outgoing word on data_o when SC_READBACK_EN is defined.
module scan_chain_loader #(
  parameter int SC_LENGTH = 1024,
  parameter int WIDTH     = 8,
  localparam int DEPTH    = SC_LENGTH / WIDTH,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_valid_o,
  output logic                 incomplete_o,
  output logic [CNT_W-1:0]     word_cnt_o,
  output logic [SC_LENGTH-1:0] chain_o,
  output logic [WIDTH-1:0]     data_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_t               state_q, state_d;
  logic [SC_LENGTH-1:0] chain_q, chain_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic                 done_q, done_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic                 incomplete_q, incomplete_d;
  logic                 handshake;

  assign ready_o   = (state_q == ST_LOAD);
  assign busy_o    = (state_q == ST_LOAD);
  assign handshake = valid_i & ready_o;

  always_comb begin
    state_d      = state_q;
    chain_d      = chain_q;
    word_cnt_d   = word_cnt_q;
    done_d       = 1'b0;
    cfg_valid_d  = cfg_valid_q;
    incomplete_d = incomplete_q;
    case (state_q)
      ST_IDLE: begin
        // The chain keeps its old contents so a new load can read them back.
        if (start) begin
          state_d      = ST_LOAD;
          word_cnt_d   = '0;
          cfg_valid_d  = 1'b0;
          incomplete_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d      = ST_IDLE;
          incomplete_d = 1'b1;
          cfg_valid_d  = 1'b0;
        end else if (handshake) begin
          chain_d = {data_i, chain_q[SC_LENGTH-1:WIDTH]};
          if (word_cnt_q != DEPTH_CNT) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
          if (word_cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cfg_valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      chain_q      <= '0;
      word_cnt_q   <= '0;
      done_q       <= 1'b0;
      cfg_valid_q  <= 1'b0;
      incomplete_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chain_q      <= chain_d;
      word_cnt_q   <= word_cnt_d;
      done_q       <= done_d;
      cfg_valid_q  <= cfg_valid_d;
      incomplete_q <= incomplete_d;
    end
  end

  assign done_o       = done_q;
  assign cfg_valid_o  = cfg_valid_q;
  assign incomplete_o = incomplete_q;
  assign word_cnt_o   = word_cnt_q;
  assign chain_o      = chain_q;

`ifdef SC_READBACK_EN
  assign data_o = chain_q[WIDTH-1:0];
`else
  assign data_o = '0;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader (SC_LENGTH=32, WIDTH=8): directed scenarios plus random traffic
// against a behavioural model of the load protocol.
module tb_scan_chain_loader;

  localparam int SC_LENGTH = 32;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = SC_LENGTH / WIDTH;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 clear = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [WIDTH-1:0]     data_i = '0;
  logic                 valid_i = 1'b0;
  logic                 ready_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 cfg_valid_o;
  logic                 incomplete_o;
  logic [CNT_W-1:0]     word_cnt_o;
  logic [SC_LENGTH-1:0] chain_o;
  logic [WIDTH-1:0]     data_o;

  scan_chain_loader #(.SC_LENGTH(SC_LENGTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .clear        (clear),
    .start        (start),
    .abort        (abort),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cfg_valid_o  (cfg_valid_o),
    .incomplete_o (incomplete_o),
    .word_cnt_o   (word_cnt_o),
    .chain_o      (chain_o),
    .data_o       (data_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  // Reference model: a load "session" flag, a pending-done flag and the chain as a number.
  bit        m_loading = 1'b0;
  bit        m_done = 1'b0;
  bit        m_cfgv = 1'b0;
  bit        m_inc = 1'b0;
  int        m_cnt = 0;
  bit [31:0] m_chain = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_done;
    if (clear) begin
      m_loading = 0; m_done = 0; m_cfgv = 0; m_inc = 0; m_cnt = 0; m_chain = '0;
    end else begin
      was_done = m_done;
      m_done = 0;
      if (was_done) begin
        m_cfgv = 1;
      end else if (m_loading) begin
        if (abort) begin
          m_loading = 0; m_inc = 1; m_cfgv = 0;
        end else if (valid_i) begin
          m_chain = (m_chain >> WIDTH) | (32'(data_i) << (SC_LENGTH - WIDTH));
          m_cnt = m_cnt + 1;
          if (m_cnt == DEPTH) begin
            m_loading = 0; m_done = 1;
          end
        end
      end else if (start) begin
        m_loading = 1; m_cnt = 0; m_cfgv = 0; m_inc = 0;
      end
    end
  endtask

  task automatic tick();
    logic [WIDTH-1:0] exp_data;
    @(posedge clk);
    model_step();
    #1;
`ifdef SC_READBACK_EN
    exp_data = m_chain[WIDTH-1:0];
`else
    exp_data = '0;
`endif
    if (done_o === 1'b1) done_seen++;
    check_eq("ready", 64'(ready_o), 64'(m_loading));
    check_eq("busy", 64'(busy_o), 64'(m_loading));
    check_eq("done", 64'(done_o), 64'(m_done));
    check_eq("cfg_valid", 64'(cfg_valid_o), 64'(m_cfgv));
    check_eq("incomplete", 64'(incomplete_o), 64'(m_inc));
    check_eq("word_cnt", 64'(word_cnt_o), 64'(m_cnt));
    check_eq("chain", 64'(chain_o), 64'(m_chain));
    check_eq("data_o", 64'(data_o), 64'(exp_data));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input int gaps);
    valid_i = 1'b1;
    data_i  = w;
    tick();
    valid_i = 1'b0;
    data_i  = $urandom_range(0, 255);
    repeat (gaps) tick();
  endtask

  logic [7:0] words [4];
  logic [7:0] rb_exp;

  initial begin
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

    // Reset
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    check_eq("rst_chain", 64'(chain_o), 64'd0);
    check_eq("rst_ready", 64'(ready_o), 64'd0);
    check_eq("rst_cnt", 64'(word_cnt_o), 64'd0);

    // Back-to-back full load
    do_start();
    for (int i = 0; i < 3; i++) send(words[i], 0);
    valid_i = 1'b1; data_i = words[3];
    tick();
    valid_i = 1'b0;
    check_eq("t2_done_pulse", 64'(done_o), 64'd1);
    tick();
    check_eq("t2_chain", 64'(chain_o), 64'h44332211);
    check_eq("t2_cfg_valid", 64'(cfg_valid_o), 64'd1);
    check_eq("t2_cnt", 64'(word_cnt_o), 64'd4);
    tick();

    // Reload of 0x55 words streams the old configuration out in order
    do_start();
    for (int i = 0; i < 4; i++) begin
`ifdef SC_READBACK_EN
      rb_exp = words[i];
`else
      rb_exp = 8'h00;
`endif
      check_eq("t6_readback", 64'(data_o), 64'(rb_exp));
      send(8'h55, 0);
    end
    tick();
    check_eq("t6_chain", 64'(chain_o), 64'h55555555);

    // Gapped load
    done_seen = 0;
    do_start();
    for (int i = 0; i < 4; i++) send(words[i], 3);
    tick();
    check_eq("t3_chain", 64'(chain_o), 64'h44332211);
    check_eq("t3_done_pulses", 64'(done_seen), 64'd1);

    // Clear mid-load, with start in the same cycle
    do_start();
    send(8'h5A, 0);
    send(8'hA5, 0);
    clear = 1'b1; start = 1'b1; valid_i = 1'b1; data_i = 8'h77;
    tick();
    clear = 1'b0; start = 1'b0; valid_i = 1'b0;
    tick();
    check_eq("t5_chain", 64'(chain_o), 64'd0);
    check_eq("t5_idle", 64'(ready_o), 64'd0);

    // Abort wins over a simultaneous handshake
    do_start();
    send(8'hAA, 0);
    send(8'hBB, 0);
    abort = 1'b1; valid_i = 1'b1; data_i = 8'hCC;
    tick();
    abort = 1'b0; valid_i = 1'b0;
    check_eq("t4_incomplete", 64'(incomplete_o), 64'd1);
    check_eq("t4_cfg_valid", 64'(cfg_valid_o), 64'd0);
    check_eq("t4_cnt", 64'(word_cnt_o), 64'd2);
    check_eq("t4_chain", 64'(chain_o), 64'hBBAA0000);
    tick();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      clear   = ($urandom_range(0, 149) == 0);
      start   = ($urandom_range(0, 5) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      data_i  = WIDTH'($urandom);
      tick();
    end
    clear = 1'b0; start = 1'b0; abort = 1'b0; valid_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
